// File: rtl/dct_pkg.sv
// Shared types for the 8x8 transpose buffer between the row and column DCT passes.
package dct_pkg;
  localparam int W     = 16;
  localparam int BLK   = 8;
  localparam int IDX_W = $clog2(BLK);

  typedef logic signed [W-1:0] coef_t;
  typedef coef_t [BLK-1:0]     vec_t;
  typedef logic [IDX_W-1:0]    idx_t;

  localparam idx_t LAST_IDX = idx_t'(BLK-1);
endpackage

// File: rtl/dct_transpose_if.sv
// Row stream in, column stream out, plus the sticky error flag.
interface dct_transpose_if;
  logic          in_valid;
  dct_pkg::vec_t in_data;
  logic          in_eob;
  logic          in_sob;
  logic          in_sof;
  logic          out_valid;
  dct_pkg::vec_t out_data;
  logic          out_eob;
  logic          out_sob;
  logic          out_sof;
  logic          out_err;

  modport master (output in_valid, in_data, in_eob, in_sob, in_sof,
                  input  out_valid, out_data, out_eob, out_sob, out_sof, out_err);
  modport slave  (input  in_valid, in_data, in_eob, in_sob, in_sof,
                  output out_valid, out_data, out_eob, out_sob, out_sof, out_err);
endinterface

// File: rtl/dct_tp_bank.sv
// One 8x8 coefficient bank: row-wide write, combinational column read.
module dct_tp_bank import dct_pkg::*; (
  input  logic clk,
  input  logic i_we,
  input  idx_t i_row,
  input  vec_t i_wdata,
  input  idx_t i_col,
  output vec_t o_col
);
  vec_t r_mem [BLK];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_row] <= i_wdata;
  end

  for (genvar i = 0; i < BLK; i++) begin : g_col
    assign o_col[i] = r_mem[i][i_col];
  end
endmodule

// File: rtl/dct_transpose.sv
// Ping-pong 8x8 transpose: rows written into one bank while the other drains as columns.
module dct_transpose import dct_pkg::*; (
  input  logic           clk,
  input  logic           rst_n,
  dct_transpose_if.slave bus
);
  logic       r_wr_bank, r_rd_bank;
  idx_t       r_wr_row, r_rd_col;
  logic [1:0] r_full, r_sof_flag;
  logic       r_pend, r_pend_bank;
  logic       r_err;
  logic       r_out_valid, r_out_sob, r_out_sof, r_out_eob;
  vec_t       r_out_data;

  vec_t       w_col [2];
  logic [1:0] w_we, w_full_nxt;
  idx_t       w_row;
  logic       w_rd_go, w_rd_last, w_busy, w_free, w_ovf, w_early, w_wr, w_wr_last, w_resync;

  assign w_row     = bus.in_sob ? '0 : r_wr_row;
  assign w_rd_go   = r_full[r_rd_bank];
  assign w_rd_last = w_rd_go && (r_rd_col == LAST_IDX);
  // A completed block becomes readable one cycle after its last row (pending stage).
  assign w_busy    = r_full[r_wr_bank] | (r_pend & (r_pend_bank == r_wr_bank));
  // Bank draining its last column this cycle may take a new row 0 on the same edge.
  assign w_free    = w_rd_last && (r_rd_bank == r_wr_bank);
  assign w_ovf     = bus.in_valid && w_busy && !w_free;
  assign w_early   = bus.in_valid && !w_ovf && bus.in_eob && (w_row != LAST_IDX);
  assign w_wr      = bus.in_valid && !w_ovf && !w_early;
  assign w_wr_last = w_wr && (w_row == LAST_IDX);
  assign w_resync  = bus.in_valid && bus.in_sob && (r_wr_row != '0);
  assign w_we      = {w_wr & r_wr_bank, w_wr & ~r_wr_bank};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_tp_bank u_bank (
      .clk     (clk),
      .i_we    (w_we[b]),
      .i_row   (w_row),
      .i_wdata (bus.in_data),
      .i_col   (r_rd_col),
      .o_col   (w_col[b])
    );
  end

  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
    if (r_pend)    w_full_nxt[r_pend_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank   <= 1'b0;
      r_wr_row    <= '0;
      r_sof_flag  <= '0;
      r_pend      <= 1'b0;
      r_pend_bank <= 1'b0;
      r_full      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_full      <= w_full_nxt;
      r_pend      <= w_wr_last;
      r_pend_bank <= r_wr_bank;
      if (w_resync || w_ovf || w_early || (w_wr_last && !bus.in_eob)) r_err <= 1'b1;
      if (w_wr) begin
        if (w_row == '0) r_sof_flag[r_wr_bank] <= bus.in_sof;
        if (w_wr_last) begin
          r_wr_bank <= ~r_wr_bank;
          r_wr_row  <= '0;
        end else begin
          r_wr_row  <= w_row + 1'b1;
        end
      end else if (w_early) begin
        r_wr_row <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_bank   <= 1'b0;
      r_rd_col    <= '0;
      r_out_valid <= 1'b0;
      r_out_sob   <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eob   <= 1'b0;
      r_out_data  <= '0;
    end else if (w_rd_go) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_col[r_rd_bank];
      r_out_sob   <= (r_rd_col == '0);
      r_out_sof   <= (r_rd_col == '0) && r_sof_flag[r_rd_bank];
      r_out_eob   <= w_rd_last;
      r_rd_col    <= r_rd_col + 1'b1;
      if (w_rd_last) r_rd_bank <= ~r_rd_bank;
    end else begin
      r_out_valid <= 1'b0;
      r_out_sob   <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eob   <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sob   = r_out_sob;
  assign bus.out_sof   = r_out_sof;
  assign bus.out_eob   = r_out_eob;
  assign bus.out_err   = r_err;
endmodule

// File: tb/tb_dct_transpose.sv
// Scoreboard bench: each block pushes its 8 expected columns; the monitor pops on out_valid.
module tb_dct_transpose;
  import dct_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dct_transpose_if bus();
  dct_transpose dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { vec_t data; logic sob; logic sof; logic eob; } exp_t;
  exp_t sb[$];
  vec_t blk [BLK];
  int   n_checks = 0, n_err = 0, n_sob = 0, mon_run = 0, max_run = 0;
  bit   mon_active = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 0;
      mon_run = 0;
    end else if (bus.out_valid) begin
      exp_t e;
      mon_run++;
      if (mon_run > max_run) max_run = mon_run;
      if (bus.out_sob) n_sob++;
      n_checks++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_col got %h sob %b sof %b eob %b", bus.out_data, bus.out_sob, bus.out_sof, bus.out_eob);
      end else begin
        e = sb.pop_front();
        if (bus.out_data !== e.data || bus.out_sob !== e.sob || bus.out_sof !== e.sof || bus.out_eob !== e.eob) begin
          n_err++;
          $display("FAIL col got %h sob %b sof %b eob %b exp %h sob %b sof %b eob %b",
                   bus.out_data, bus.out_sob, bus.out_sof, bus.out_eob, e.data, e.sob, e.sof, e.eob);
        end
      end
      mon_active = !bus.out_eob;
    end else begin
      mon_run = 0;
      n_checks++;
      if (mon_active || bus.out_sob || bus.out_sof || bus.out_eob) begin
        n_err++;
        $display("FAIL idle_or_gap active %0b sob %b sof %b eob %b exp all 0", mon_active, bus.out_sob, bus.out_sof, bus.out_eob);
      end
      mon_active = 0;
    end
  end

  task automatic drive_row(input vec_t d, input logic sob, input logic sof, input logic eob);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sob = sob; bus.in_sof = sof; bus.in_eob = eob;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_sob = 1'b0; bus.in_sof = 1'b0; bus.in_eob = 1'b0;
  endtask

  task automatic fill_pattern(input int base);
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++) blk[r][c] = coef_t'(base + r*8 + c);
  endtask

  task automatic send_block(input logic sof, input int gap_max);
    exp_t e;
    for (int c = 0; c < BLK; c++) begin
      for (int i = 0; i < BLK; i++) e.data[i] = blk[i][c];
      e.sob = (c == 0); e.sof = sof && (c == 0); e.eob = (c == BLK-1);
      sb.push_back(e);
    end
    for (int r = 0; r < BLK; r++) begin
      drive_row(blk[r], r == 0, sof && (r == 0), r == BLK-1);
      if (r < BLK-1 && gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !mon_active) begin ok = 1; break; end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_sob !== 1'b0 || bus.out_sof !== 1'b0 ||
        bus.out_eob !== 1'b0 || bus.out_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs got v%b d%h s%b f%b e%b err%b exp all 0",
               bus.out_valid, bus.out_data, bus.out_sob, bus.out_sof, bus.out_eob, bus.out_err);
    end
    apply_reset();
  endtask

  task automatic test_identity();
    bit ok;
    fill_pattern(0);
    send_block(1'b1, 0);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL latency_t0 got %b exp 0", bus.out_valid); end
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL latency_t1 got %b exp 0", bus.out_valid); end
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sob !== 1'b1 || bus.out_sof !== 1'b1) begin
      n_err++; $display("FAIL latency_t2 got v%b sob%b sof%b exp 111", bus.out_valid, bus.out_sob, bus.out_sof);
    end
    wait_drain(ok);
    n_checks++;
    if (!ok) begin n_err++; $display("FAIL identity_drain left %0d exp 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int sob0;
    sob0 = n_sob;
    max_run = 0;
    for (int b = 0; b < 4; b++) begin
      fill_pattern(100 + 1000*b);
      send_block(b == 0, 0);
    end
    wait_drain(ok);
    n_checks++;
    if (!ok) begin n_err++; $display("FAIL b2b_drain left %0d exp 0", sb.size()); end
    n_checks++;
    if (max_run != 32) begin n_err++; $display("FAIL b2b_run got %0d exp 32", max_run); end
    n_checks++;
    if (n_sob - sob0 != 4) begin n_err++; $display("FAIL b2b_blocks got %0d exp 4", n_sob - sob0); end
    n_checks++;
    if (bus.out_err !== 1'b0) begin n_err++; $display("FAIL b2b_err got %b exp 0", bus.out_err); end
  endtask

  task automatic test_gapped();
    bit ok;
    fill_pattern(0);
    send_block(1'b1, 3);
    wait_drain(ok);
    n_checks++;
    if (!ok) begin n_err++; $display("FAIL gapped_drain left %0d exp 0", sb.size()); end
    n_checks++;
    if (bus.out_err !== 1'b0) begin n_err++; $display("FAIL gapped_err got %b exp 0", bus.out_err); end
  endtask

  task automatic test_early_eob();
    bit ok;
    int sob0;
    fill_pattern(500);
    for (int r = 0; r < 5; r++) drive_row(blk[r], r == 0, 1'b0, r == 4);
    repeat (12) @(negedge clk);
    n_checks++;
    if (bus.out_err !== 1'b1) begin n_err++; $display("FAIL early_eob_err got %b exp 1", bus.out_err); end
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++)
        blk[r][c] = (c == 3) ? -16'sd1 : (c == 5) ? 16'sd1 : ((r + c) % 2 == 1) ? 16'sh7FFF : 16'sh8000;
    sob0 = n_sob;
    send_block(1'b0, 0);
    wait_drain(ok);
    n_checks++;
    if (!ok || n_sob - sob0 != 1) begin n_err++; $display("FAIL early_eob_next got %0d blocks exp 1", n_sob - sob0); end
    n_checks++;
    if (bus.out_err !== 1'b1) begin n_err++; $display("FAIL early_eob_sticky got %b exp 1", bus.out_err); end
  endtask

  task automatic test_resync();
    bit ok;
    int sob0;
    apply_reset();
    n_checks++;
    if (bus.out_err !== 1'b0) begin n_err++; $display("FAIL resync_pre_err got %b exp 0", bus.out_err); end
    sob0 = n_sob;
    fill_pattern(-700);
    for (int r = 0; r < 3; r++) drive_row(blk[r], r == 0, 1'b0, 1'b0);
    fill_pattern(2000);
    send_block(1'b1, 0);
    wait_drain(ok);
    repeat (10) @(negedge clk);
    n_checks++;
    if (!ok || n_sob - sob0 != 1) begin n_err++; $display("FAIL resync_blocks got %0d exp 1", n_sob - sob0); end
    n_checks++;
    if (bus.out_err !== 1'b1) begin n_err++; $display("FAIL resync_err got %b exp 1", bus.out_err); end
  endtask

  task automatic test_reset_mid();
    bit ok, found;
    int sob0;
    fill_pattern(3000);
    send_block(1'b0, 0);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_data[0] === blk[0][3]) begin found = 1; break; end
    end
    n_checks++;
    if (!found) begin n_err++; $display("FAIL reset_mid_col3 got none exp col 3"); end
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_eob !== 1'b0 || bus.out_sob !== 1'b0 || bus.out_err !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_outputs got v%b d%h e%b err%b exp 0", bus.out_valid, bus.out_data, bus.out_eob, bus.out_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    sob0 = n_sob;
    fill_pattern(4000);
    send_block(1'b1, 0);
    wait_drain(ok);
    n_checks++;
    if (!ok || n_sob - sob0 != 1) begin n_err++; $display("FAIL reset_mid_after got %0d blocks exp 1", n_sob - sob0); end
    n_checks++;
    if (bus.out_err !== 1'b0) begin n_err++; $display("FAIL reset_mid_err got %b exp 0", bus.out_err); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sob = 1'b0; bus.in_sof = 1'b0; bus.in_eob = 1'b0;
    test_reset();
    test_identity();
    test_back_to_back();
    test_gapped();
    test_early_eob();
    test_resync();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
